// File: rtl/uart_tx_arbiter.sv
// Round-robin, message-granular arbiter sharing one UART transmitter between byte streams.
// A grant lasts until the owner's byte carries last or the burst cap is reached.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 2,
    parameter int MAX_BURST = 16,
    localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1,
    localparam int CW = $clog2(MAX_BURST + 1)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [8*NUM_REQ-1:0]   req_data,
    input  logic [NUM_REQ-1:0]     req_valid,
    input  logic [NUM_REQ-1:0]     req_last,
    output logic [NUM_REQ-1:0]     req_ready,
    output logic [7:0]             tx_data,
    output logic                   tx_valid,
    input  logic                   tx_ready,
    output logic [NUM_REQ-1:0]     grant,
    output logic                   busy,
    output logic                   dbg_hold,
    output logic [PW-1:0]          dbg_ptr
);

    // Handshakes: a transfer happens on a rising edge where valid & ready are both high.
    // req_ready depends only on registered state and tx_ready, never on req_valid.
    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

    state_t               r_state;
    logic [PW-1:0]        r_ptr;
    logic [PW-1:0]        r_owner;
    logic [CW-1:0]        r_count;
    logic [7:0]           r_tx_data;
    logic                 r_tx_valid;
    logic [NUM_REQ-1:0]   r_grant;

    logic                 w_hold;
    logic                 w_slot_free;
    logic                 w_own_valid;
    logic                 w_own_last;
    logic [7:0]           w_own_data;
    logic                 w_accept;
    logic                 w_release;
    logic                 w_found;
    logic [PW-1:0]        w_pick;
    logic [PW-1:0]        w_next_ptr;

    assign w_hold      = (r_state == S_HOLD);
    assign w_slot_free = ~r_tx_valid | tx_ready;

    always_comb begin
        w_own_valid = 1'b0;
        w_own_last  = 1'b0;
        w_own_data  = 8'h00;
        req_ready   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (PW'(i) == r_owner) begin
                w_own_valid  = req_valid[i];
                w_own_last   = req_last[i];
                w_own_data   = req_data[8*i +: 8];
                req_ready[i] = w_hold & w_slot_free;
            end
        end
    end

    assign w_accept  = w_hold & w_own_valid & w_slot_free;
    // Last byte and burst cap landing together still release only once.
    assign w_release = w_accept & (w_own_last | (int'(r_count) == MAX_BURST - 1));

    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = (int'(r_ptr) + k) % NUM_REQ;
            if (!w_found && req_valid[idx]) begin
                w_found = 1'b1;
                w_pick  = PW'(idx);
            end
        end
    end

    assign w_next_ptr = (int'(r_owner) == NUM_REQ - 1) ? '0 : r_owner + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= '0;
            r_owner    <= '0;
            r_count    <= '0;
            r_grant    <= '0;
            r_tx_data  <= 8'h00;
            r_tx_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_owner <= w_pick;
                        r_grant <= NUM_REQ'(1) << w_pick;
                        r_count <= '0;
                        r_state <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (w_accept) begin
                        r_count <= r_count + 1'b1;
                    end
                    if (w_release) begin
                        r_state <= S_IDLE;
                        r_grant <= '0;
                        r_ptr   <= w_next_ptr;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            // Output stage drains independently of the grant state.
            if (w_accept) begin
                r_tx_data  <= w_own_data;
                r_tx_valid <= 1'b1;
            end else if (tx_ready) begin
                r_tx_valid <= 1'b0;
            end
        end
    end

    assign tx_data  = r_tx_data;
    assign tx_valid = r_tx_valid;
    assign grant    = r_grant;
    assign busy     = w_hold | r_tx_valid;
    assign dbg_hold = w_hold;
    assign dbg_ptr  = r_ptr;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed timing steps, then random streams checked against
// a message-level round-robin model that predicts the full output byte order.
module tb_uart_tx_arbiter;

    localparam int NR = 2;
    localparam int MB = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [15:0]    req_data = '0;
    logic [1:0]     req_valid = '0;
    logic [1:0]     req_last = '0;
    logic [1:0]     req_ready;
    logic [7:0]     tx_data;
    logic           tx_valid;
    logic           tx_ready = 1'b0;
    logic [1:0]     grant;
    logic           busy;
    logic           dbg_hold;
    logic           dbg_ptr;

    int total = 0;
    int bad = 0;

    logic [7:0] exp_q[$];
    logic [7:0] src_d[NR][64];
    logic       src_l[NR][64];
    int         src_n[NR];
    int         sp[NR];

    uart_tx_arbiter #(.NUM_REQ(NR), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_data(req_data), .req_valid(req_valid), .req_last(req_last),
        .req_ready(req_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .grant(grant), .busy(busy), .dbg_hold(dbg_hold), .dbg_ptr(dbg_ptr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = '0;
        req_last = '0;
        req_data = '0;
        tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic build_expected();
        int ptr;
        int rd[NR];
        int cnt;
        int sel;
        logic lst;
        ptr = 0;
        for (int i = 0; i < NR; i++) rd[i] = 0;
        forever begin
            sel = -1;
            for (int k = 0; k < NR; k++) begin
                int j;
                j = (ptr + k) % NR;
                if (sel < 0 && rd[j] < src_n[j]) sel = j;
            end
            if (sel < 0) break;
            cnt = 0;
            do begin
                exp_q.push_back(src_d[sel][rd[sel]]);
                lst = src_l[sel][rd[sel]];
                rd[sel]++;
                cnt++;
            end while (!lst && cnt < MB);
            ptr = (sel + 1) % NR;
        end
    endtask

    initial begin
        int cyc;
        int stall;
        logic prev_stall;
        logic [7:0] prev_data;

        // Reset values and single-byte message timing.
        do_reset();
        chk("rst_grant", grant, 0);
        chk("rst_ready", req_ready, 0);
        chk("rst_tx_valid", tx_valid, 0);
        chk("rst_tx_data", tx_data, 0);
        chk("rst_busy", busy, 0);
        chk("rst_ptr", dbg_ptr, 0);

        req_valid = 2'b01; req_data = 16'h0041; req_last = 2'b01; tx_ready = 1'b1;
        @(negedge clk);
        chk("c0_grant", grant, 0);
        chk("c0_ready", req_ready, 0);
        next_cycle();
        @(negedge clk);
        chk("c1_grant", grant, 2'b01);
        chk("c1_ready", req_ready, 2'b01);
        chk("c1_tx_valid", tx_valid, 0);
        next_cycle();
        req_valid = 2'b00; req_last = 2'b00;
        @(negedge clk);
        chk("c2_tx_valid", tx_valid, 1);
        chk("c2_tx_data", tx_data, 8'h41);
        chk("c2_grant", grant, 0);
        chk("c2_busy", busy, 1);
        chk("c2_ptr", dbg_ptr, 1);
        next_cycle();
        @(negedge clk);
        chk("c3_tx_valid", tx_valid, 0);
        chk("c3_busy", busy, 0);

        // Pointer now at 1: req1 wins the tie, then req0 after the bubble.
        next_cycle();
        req_valid = 2'b11; req_data = 16'h2211; req_last = 2'b11;
        @(negedge clk);
        chk("rr_idle_grant", grant, 0);
        next_cycle();
        @(negedge clk);
        chk("rr_grant1", grant, 2'b10);
        chk("rr_ready1", req_ready, 2'b10);
        next_cycle();
        req_valid = 2'b01;
        @(negedge clk);
        chk("rr_bubble_grant", grant, 0);
        chk("rr_byte1", tx_data, 8'h22);
        chk("rr_ptr", dbg_ptr, 0);
        next_cycle();
        @(negedge clk);
        chk("rr_grant0", grant, 2'b01);
        next_cycle();
        req_valid = 2'b00; req_last = 2'b00;
        @(negedge clk);
        chk("rr_byte0", tx_data, 8'h11);

        // Asynchronous reset after req1's second accepted byte.
        do_reset();
        req_valid = 2'b10; req_data = 16'h5100; req_last = 2'b00; tx_ready = 1'b1;
        next_cycle();
        next_cycle();
        req_data = 16'h5200;
        next_cycle();
        @(negedge clk);
        chk("mid_tx_valid", tx_valid, 1);
        chk("mid_tx_data", tx_data, 8'h52);
        #2 rst_n = 1'b0;
        req_valid = 2'b11; req_data = 16'h6160; req_last = 2'b11;
        #1;
        chk("arst_tx_valid", tx_valid, 0);
        chk("arst_grant", grant, 0);
        chk("arst_ready", req_ready, 0);
        chk("arst_busy", busy, 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("post_rst_grant", grant, 2'b01);
        next_cycle();
        req_valid = 2'b00; req_last = 2'b00;
        @(negedge clk);
        chk("post_rst_byte", tx_data, 8'h60);

        // Random streams with owner gaps and transmitter backpressure.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            int n;
            n = 0;
            while (n < 40) begin
                int len;
                len = $urandom_range(1, 7);
                for (int b = 0; b < len; b++) begin
                    src_d[i][n] = 8'(i * 128 + n);
                    src_l[i][n] = (b == len - 1);
                    n++;
                end
            end
            src_n[i] = n;
            sp[i] = 0;
        end
        build_expected();

        cyc = 0;
        stall = 0;
        prev_stall = 1'b0;
        prev_data = 8'h00;
        while (cyc < 4000 && (exp_q.size() > 0 || busy)) begin
            @(posedge clk);
            #1;
            if (stall > 0) begin
                tx_ready = 1'b0;
                stall--;
            end else if ($urandom_range(0, 19) == 0) begin
                tx_ready = 1'b0;
                stall = 4;
            end else begin
                tx_ready = ($urandom_range(0, 3) != 0);
            end
            for (int i = 0; i < NR; i++) begin
                if (sp[i] < src_n[i]) begin
                    req_valid[i] = !grant[i] || ($urandom_range(0, 3) != 0);
                    req_data[8*i +: 8] = src_d[i][sp[i]];
                    req_last[i] = src_l[i][sp[i]];
                end else begin
                    req_valid[i] = 1'b0;
                    req_data[8*i +: 8] = 8'h00;
                    req_last[i] = 1'b0;
                end
            end
            @(negedge clk);
            chk("grant_onehot", 32'($countones(grant) <= 1), 1);
            chk("ready_owner", req_ready & ~grant, 0);
            if (tx_valid && !tx_ready) chk("ready_stall", req_ready, 0);
            if (prev_stall) begin
                chk("hold_valid", tx_valid, 1);
                chk("hold_data", tx_data, prev_data);
            end
            prev_stall = tx_valid & ~tx_ready;
            prev_data = tx_data;
            for (int i = 0; i < NR; i++) begin
                if (req_valid[i] && req_ready[i]) sp[i]++;
            end
            if (tx_valid && tx_ready) begin
                total++;
                assert (exp_q.size() != 0) else begin
                    bad++;
                    $error("FAIL extra_byte: observed=%0h expected=none", tx_data);
                end
                if (exp_q.size() != 0) chk("tx_byte", tx_data, exp_q.pop_front());
            end
            cyc++;
        end
        chk("all_sent", exp_q.size(), 0);
        chk("src0_drained", sp[0], src_n[0]);
        chk("src1_drained", sp[1], src_n[1]);
        next_cycle();
        @(negedge clk);
        chk("end_idle_grant", grant, 0);
        chk("end_tx_valid", tx_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
